// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte frame
// into a 16 x 9-bit instruction store and holds the processor in reset until it verifies.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int IW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  input  logic [3:0]    rd_addr,
  output logic [IW-1:0] rd_instr,
  output logic          cpu_rst,
  output logic          loaded,
  output logic          error
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      rem_q, rem_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      lo_q, lo_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            loaded_q, loaded_d;
  logic            error_q, error_d;
  logic [IW-1:0]   mem_q [DEPTH];

  logic            accept;
  logic            mem_we;
  logic [IW-1:0]   mem_wdata;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_LO) ||
                     (state_q == S_HI)  || (state_q == S_CSUM);
  assign accept    = in_valid && in_ready;
  // Only HI[0] is stored; the remaining HI bits still feed the checksum.
  assign mem_wdata = {in_data[IW-9:0], lo_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    lo_d    = lo_q;
    mem_we  = 1'b0;

    case (state_q)
      S_LEN: begin
        if (accept) begin
          if ((in_data == 8'd0) || (in_data > 8'(DEPTH))) begin
            state_d = S_ERR;
          end else begin
            rem_d   = in_data[4:0];
            idx_d   = 4'd0;
            csum_d  = in_data;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          mem_we  = 1'b1;
          csum_d  = csum_q ^ in_data;
          idx_d   = idx_q + 4'd1;
          rem_d   = rem_q - 5'd1;
          state_d = (rem_q == 5'd1) ? S_CSUM : S_LO;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d = S_LEN;
        end
      end
      default: state_d = S_LEN;
    endcase

    cpu_rst_d = (state_d != S_RUN);
    loaded_d  = (state_d == S_RUN);
    error_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LEN;
      idx_q     <= 4'd0;
      rem_q     <= 5'd0;
      csum_q    <= 8'd0;
      lo_q      <= 8'd0;
      cpu_rst_q <= 1'b1;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      lo_q      <= lo_d;
      cpu_rst_q <= cpu_rst_d;
      loaded_q  <= loaded_d;
      error_q   <= error_d;
    end
  end

  // Reset clears the whole store so the processor only ever sees no-ops before a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  assign rd_instr = mem_q[rd_addr];
  assign cpu_rst  = cpu_rst_q;
  assign loaded   = loaded_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus random frames, checked against a
// frame-level model of the instruction store and load status.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       reload = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       in_ready;
  logic [8:0] rd_instr;
  logic       cpu_rst;
  logic       loaded;
  logic       error;

  prog_loader #(.DEPTH(16), .IW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .rd_addr  (rd_addr),
    .rd_instr (rd_instr),
    .cpu_rst  (cpu_rst),
    .loaded   (loaded),
    .error    (error)
  );

  always #5 clk = ~clk;

  localparam int LOADING = 0;
  localparam int RUNNING = 1;
  localparam int FAILED  = 2;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] mem_m [16];
  int         st_m;
  logic [7:0] fr [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level model: what the store and status must be once a whole frame is in.
  task automatic model_frame();
    int         len;
    logic [7:0] x;
    len = int'(fr[0]);
    if (len == 0 || len > 16) begin
      st_m = FAILED;
      return;
    end
    x = 8'd0;
    for (int k = 0; k <= 2 * len; k++) x ^= fr[k];
    for (int i = 0; i < len; i++) mem_m[i] = {fr[2 + 2 * i][0], fr[1 + 2 * i]};
    st_m = (fr[2 * len + 1] == x) ? RUNNING : FAILED;
  endtask

  // pattern 0: random words; pattern 1: word i = {i[0], i*8'h11}
  task automatic build_frame(input int len, input int pattern, input bit corrupt);
    logic [8:0] w;
    logic [7:0] hi;
    logic [7:0] x;
    logic [7:0] len8;
    fr.delete();
    len8 = 8'(len);
    fr.push_back(len8);
    if (len == 0 || len > 16) return;
    x = len8;
    for (int i = 0; i < len; i++) begin
      if (pattern == 1) w = {1'(i), 8'(i * 17)};
      else              w = 9'($urandom);
      hi = {7'($urandom), w[8]};
      fr.push_back(w[7:0]);
      fr.push_back(hi);
      x = x ^ w[7:0] ^ hi;
    end
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    fr.push_back(x);
  endtask

  // gap_mode 0: back-to-back, 1: one idle cycle before each byte, 2: random 0..2 idles
  task automatic send_frame(input int gap_mode);
    int len;
    int gaps;
    len = int'(fr[0]);
    for (int k = 0; k < fr.size(); k++) begin
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      check("in_ready_in_frame", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = fr[k];
      reload   = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reload   = 1'b0;
      if (k >= 2 && (k % 2) == 0 && len >= 1 && len <= 16 && k <= 2 * len) begin
        rd_addr = 4'(k / 2 - 1);
        #1;
        check($sformatf("live_write_w%0d", k / 2 - 1), 32'(rd_instr), 32'({fr[k][0], fr[k - 1]}));
      end
      if (k != fr.size() - 1) check("cpu_rst_mid_frame", 32'(cpu_rst), 32'd1);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_w%0d", tag, i), 32'(rd_instr), 32'(mem_m[i]));
    end
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'(st_m != RUNNING));
    check({tag, "_loaded"},   32'(loaded),   32'(st_m == RUNNING));
    check({tag, "_error"},    32'(error),    32'(st_m == FAILED));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(st_m == LOADING));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    st_m = LOADING;
    check("reload_in_ready", 32'(in_ready), 32'd1);
    check("reload_error",    32'(error),    32'd0);
    check("reload_loaded",   32'(loaded),   32'd0);
    check("reload_cpu_rst",  32'(cpu_rst),  32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) mem_m[i] = 9'h000;
    st_m = LOADING;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 9'h000;
    st_m = LOADING;
    #2;
    do_reset();

    // basic load
    fr = '{8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    model_frame();
    send_frame(0);
    check("basic_loaded", 32'(loaded), 32'd1);
    rd_addr = 4'd0; #1; check("basic_w0", 32'(rd_instr), 32'h112);
    rd_addr = 4'd1; #1; check("basic_w1", 32'(rd_instr), 32'h034);
    rd_addr = 4'd2; #1; check("basic_w2", 32'(rd_instr), 32'h000);
    check_all("basic");

    // checksum error, then recovery
    do_reload();
    fr = '{8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h24};
    model_frame();
    send_frame(0);
    check("csum_err_error", 32'(error), 32'd1);
    check_all("csum_err");
    do_reload();
    fr = '{8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    model_frame();
    send_frame(2);
    check_all("csum_recover");

    // bad lengths on a fresh store
    do_reset();
    fr = '{8'h00};
    model_frame();
    send_frame(0);
    check("badlen0_error", 32'(error), 32'd1);
    check_all("badlen0");
    do_reload();
    fr = '{8'h11};
    model_frame();
    send_frame(0);
    check_all("badlen17");

    // full depth with back-pressure; first a corrupted sum, then the good one
    do_reload();
    build_frame(16, 1, 1'b1);
    model_frame();
    send_frame(1);
    check_all("full_bad");
    do_reload();
    build_frame(16, 1, 1'b0);
    model_frame();
    send_frame(1);
    check("full_w15", 32'(mem_m[15]), 32'h1ff);
    check_all("full");

    // reload preserves tail
    do_reload();
    build_frame(4, 0, 1'b0);
    model_frame();
    send_frame(0);
    check_all("tail4");
    do_reload();
    build_frame(1, 0, 1'b0);
    model_frame();
    send_frame(0);
    check_all("tail1");

    // reset mid-load, then a fresh frame
    do_reset();
    fr = '{8'h02, 8'h12, 8'h01};
    send_frame(0);
    do_reset();
    fr = '{8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    model_frame();
    send_frame(0);
    check_all("after_abort");

    // random frames
    for (int n = 0; n < 40; n++) begin
      int len;
      if (st_m != LOADING) do_reload();
      len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255))
                                        : $urandom_range(1, 16);
      build_frame(len, 0, $urandom_range(0, 3) == 0);
      model_frame();
      send_frame(2);
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader and writable instruction store for the 4-stage pipelined processor. It replaces the fixed program ROM. It receives a length-prefixed, checksummed byte stream from a host link and writes the stream into a 16 x 9-bit instruction array. The processor fetches from that array through a combinational read port, and the block holds the processor in reset until a complete, checksum-verified program has been loaded.

## Interface
Parameters:
- DEPTH, 16, number of instruction words; index width is 4 bits.
- IW, 9, instruction width (3-bit opcode + 2-bit dest + 4-bit operand field).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  block accepts a byte this cycle.
- reload  in  1  single-cycle request to start a new load; honoured only in RUN or ERR.
- rd_addr  in  4  processor fetch address (PC).
- rd_instr  out  9  instruction at rd_addr; combinational.
- cpu_rst  out  1  reset to the processor; high until a load succeeds.
- loaded  out  1  high in RUN.
- error  out  1  high in ERR.

## Operation
- Transfer rule: a byte is accepted on a rising edge when in_valid && in_ready. in_ready depends only on state.
  - in_ready = 1 in LEN, LO, HI and CSUM.
  - in_ready = 0 in RUN and ERR.
- Frame format: LEN byte, then LEN pairs (LO, HI), then a CSUM byte.
  - LEN must be 1..16; instruction = {HI[0], LO}.
  - HI[7:1] is ignored for storage but is included in the checksum.
- Running checksum csum (8 bit) = XOR of LEN and all payload bytes.
- Counters: idx (4 bit) is the write index; remaining (5 bit) is the number of words left.
- FSM:
  - LEN: on accept, the byte is checked.
    - If the byte is 0 or >16: go to ERR.
    - Otherwise: remaining <= byte, idx <= 0, csum <= byte, go to LO.
  - LO: on accept, latch lo <= byte, csum ^= byte, go to HI.
  - HI: on accept:
    - mem[idx] <= {byte[0], lo}; csum ^= byte; idx++; remaining--.
    - If remaining == 1 (this was the last word): go to CSUM; otherwise go to LO.
  - CSUM: on accept:
    - If byte == csum: go to RUN.
    - Otherwise: go to ERR.
  - RUN: cpu_rst = 0. reload goes to LEN.
  - ERR: cpu_rst = 1. reload goes to LEN.
  - reload in LEN, LO, HI or CSUM is ignored.
- Words beyond LEN keep their previous contents.
- A failed load may leave partially overwritten words. This is harmless because the processor stays in reset.
- The read port is always live, including during a load. It returns the current array contents.

## Timing
- Reset (async, immediate):
  - state = LEN, in_ready = 1, cpu_rst = 1, loaded = 0, error = 0.
  - idx = 0, remaining = 0, csum = 0, lo = 0.
  - All mem words = 9'h000. Opcode 000 is a pipeline no-op.
- cpu_rst, loaded and error are registered state decodes.
  - cpu_rst falls and loaded rises at the edge that accepts a matching CSUM byte.
  - error rises at the edge that accepts a bad LEN byte or a bad CSUM byte.
- Array write occurs at the edge accepting the HI byte. rd_instr reflects the new word after that edge, with no further delay.
- reload in RUN or ERR:
  - Next edge: state = LEN, cpu_rst = 1, loaded = 0, error = 0.
  - in_ready rises in the same cycle as the state change.
- Host may deassert in_valid at any point. State holds with no timeout.
- Reset asserted mid-frame aborts the frame and clears the array. The next byte is interpreted as LEN.
- Minimum frame time: 2·LEN + 2 accepted bytes. Full 16-word load takes 34 cycles at one byte per cycle.

## Test plan
- Basic load: bytes 02, 12, 01, 34, 00, 25 with in_valid continuous.
  - mem[0] = 9'h112 and mem[1] = 9'h034.
  - cpu_rst falls at the 6th accept edge; loaded = 1, in_ready = 0.
  - rd_addr = 2 returns 9'h000.
- Checksum error: same frame with final byte 24.
  - error = 1, cpu_rst stays 1, in_ready = 0.
  - reload pulse gives error = 0 and in_ready = 1 the next cycle.
  - Resending the correct frame reaches RUN.
- Bad length: first byte 00, then separately first byte 11.
  - Each goes directly to ERR on that edge.
  - No mem write occurs: all words remain 000.
- Full depth with back-pressure: LEN = 10, 16 words with pattern word i = {i[0], i*8'h11}, with in_valid toggled every other cycle.
  - All 16 words are correct and idx wraps to 0.
  - RUN is entered only after the correct CSUM.
- Reset mid-load: assert rst after the 3rd byte of a 2-word frame.
  - cpu_rst = 1 and mem[0] = 000 immediately.
  - A fresh full frame afterwards loads correctly.
- Reload preserves tail: load 4 words, then reload with LEN = 1.
  - Words 1..3 are retained and word 0 is updated.
  - cpu_rst is high throughout the second frame.
